// File: rtl/prog_timer.sv
// Programmable interval timer: counts enabled ticks from 0 up to a loaded period,
// then pulses done and either returns to IDLE (one-shot) or wraps (periodic).
module prog_timer #(
  parameter int WIDTH          = 24,
  parameter int DEFAULT_PERIOD = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_periodReg;
  logic [WIDTH-1:0] r_activePeriod;
  logic             r_modeReg;
  logic             r_done;

  logic             w_terminal;
  logic [WIDTH-1:0] w_startPeriod;

  assign w_terminal    = (r_count == r_activePeriod);
  assign w_startPeriod = load ? period_in : r_periodReg;

  // Priority is stop > start > tick; a wrap reloads from the period register so
  // loads issued mid-run only take effect at the next expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_periodReg    <= RESET_PERIOD;
      r_activePeriod <= RESET_PERIOD;
      r_modeReg      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load)
        r_periodReg <= period_in;

      if (stop) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (start) begin
        r_activePeriod <= w_startPeriod;
        r_modeReg      <= mode;
        r_count        <= '0;
        r_state        <= RUN;
      end else if (r_state == RUN && enable) begin
        if (w_terminal) begin
          r_count <= '0;
          r_done  <= 1'b1;
          if (r_modeReg)
            r_activePeriod <= r_periodReg;
          else
            r_state <= IDLE;
        end else begin
          r_count <= r_count + WIDTH'(1);
        end
      end
    end
  end

  assign count = r_count;
  assign busy  = (r_state == RUN);
  assign done  = r_done;

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 24: counter and period width in bits; legal range 2..32.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 255: reset value of the period register; SHALL be < 2**WIDTH.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: tick qualifier; the counter advances only on cycles with enable=1.
REQ-006 SHALL have port start, input, 1: single-cycle request to begin or restart a timing run.
REQ-007 SHALL have port stop, input, 1: single-cycle request to abort a run.
REQ-008 SHALL have port mode, input, 1: 0 = one-shot, 1 = periodic; sampled only with start.
REQ-009 SHALL have port load, input, 1: write strobe for the period register.
REQ-010 SHALL have port period_in, input, WIDTH: period value written on load.
REQ-011 SHALL have port count, output, WIDTH: current counter value, registered.
REQ-012 SHALL have port busy, output, 1: high while in RUN.
REQ-013 SHALL have port done, output, 1: registered pulse, high for exactly one clk per expiry.

Function
REQ-014 SHALL implement two states: IDLE and RUN.
REQ-015 SHALL update period_reg <= period_in on any cycle with load=1, in either state.
REQ-016 SHALL copy the period into active_period and mode into mode_reg when start=1 and stop=0.
REQ-017 SHALL take the copied period from period_in if load=1 in the same cycle, otherwise from period_reg.
REQ-018 SHALL give a start accepted under REQ-016 these effects: count <= 0, state <= RUN, in both IDLE and RUN (restart).
REQ-019 SHALL prioritise inputs as stop > start > tick; stop=1 forces state <= IDLE and count <= 0.
REQ-020 SHALL treat stop=1 in IDLE as having no effect other than holding count at 0.
REQ-021 SHALL, in RUN with enable=1 and count != active_period, set count <= count + 1.
REQ-022 SHALL define a terminal tick as a cycle in RUN with enable=1 and count == active_period.
REQ-023 SHALL, on a terminal tick, set count <= 0 and assert done on the following cycle only.
REQ-024 SHALL give one expiry every active_period+1 enable ticks.
REQ-025 SHALL, on a terminal tick with mode_reg=0, set state <= IDLE; busy deasserts on the same edge that raises done.
REQ-026 SHALL, on a terminal tick with mode_reg=1, remain in RUN and reload active_period from period_reg, so loads take effect at the next wrap.
REQ-027 SHALL, for active_period=0, make every enabled RUN cycle a terminal tick (done every tick in periodic mode).
REQ-028 SHALL hold count and state unchanged in RUN with enable=0 (pause); done stays 0.
REQ-029 SHALL suppress done for a terminal-tick condition in a cycle where stop=1 or start=1.
REQ-030 SHALL keep count from exceeding active_period; the count+1 path SHALL never wrap through 2**WIDTH.
REQ-031 SHALL leave mode changes outside a start cycle without effect on a run in progress.

Reset
REQ-032 SHALL, while reset_n=0, immediately force: state=IDLE, count=0, busy=0, done=0, period_reg=DEFAULT_PERIOD, active_period=DEFAULT_PERIOD, mode_reg=0.
REQ-033 SHALL abandon a run when reset is asserted mid-run; after release the block waits in IDLE for start, with no done emitted.

Verification
REQ-034 SHALL cover one-shot: load period_in=3, start mode=0, enable held 1 -> count 0,1,2,3, then done=1 for one cycle, busy=0, count=0.
REQ-035 SHALL cover periodic: period 4, mode=1, enable=1 -> done every 5 cycles; load 1 mid-run -> spacing becomes 2 only after the next done.
REQ-036 SHALL cover pause: period 5, enable toggled 1/0 -> done after exactly 6 enabled cycles; count frozen when enable=0.
REQ-037 SHALL cover stop and restart: stop at count=2 -> busy=0, count=0, no done; start in RUN at count=2 -> count=0, full period re-timed.
REQ-038 SHALL cover edges: period_in=0 periodic -> done on every enabled cycle; start+load same cycle with period_in=7 -> 8-tick run.
REQ-039 SHALL cover reset mid-run: assert reset_n=0 at count=10 -> outputs reset asynchronously; period_reg=DEFAULT_PERIOD (255); no done after release.
